// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM link: lock-state encoding and a width helper
// used by both the receive demux and the matching transmitter.
package tdm_demux_pkg;

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    // Ceiling log2, never below 1 so that a slot index always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-NCH slot counter with synchronous clear, load-to-one on frame start, and
// a combinational wrap flag raised when the last slot is being consumed.
module tdm_slot_counter
    import tdm_demux_pkg::*;
#(
    parameter int NCH = 4,
    parameter int SW  = clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load1,
    input  logic          inc,
    output logic [SW-1:0] count,
    output logic          wrap
);

    localparam logic [SW-1:0] LAST = SW'(NCH - 1);

    logic [SW-1:0] count_reg;

    assign count = count_reg;
    assign wrap  = inc && (count_reg == LAST);

    // Explicit wrap at NCH-1 so non-power-of-two frame lengths work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load1) begin
            count_reg <= SW'(1);
        end else if (inc) begin
            count_reg <= wrap ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM receiver: aligns to frame_sync, collects NCH slots in a shadow buffer and
// publishes each complete frame to ch_data atomically with a frame_valid pulse.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W-1:0]           din,
    input  logic                   din_valid,
    input  logic                   frame_sync,
    output logic [NCH*W-1:0]       ch_data,
    output logic                   frame_valid,
    output logic                   locked,
    output logic                   sync_err,
    output logic [clog2(NCH)-1:0]  slot_idx
);

    localparam int SW = clog2(NCH);

    logic [0:0]        state_reg;
    logic [W-1:0]      shadow_reg [NCH-1];
    logic [NCH*W-1:0]  ch_data_reg;
    logic [NCH*W-1:0]  ch_data_next;
    logic              frame_valid_reg;
    logic              sync_err_reg;
    logic [SW-1:0]     count;
    logic              wrap;
    logic              is_locked;
    logic              start;
    logic              take;
    logic              early_sync;
    logic              missing_sync;

    assign is_locked    = (state_reg == LOCKED);
    assign start        = din_valid && frame_sync;
    assign early_sync   = start && is_locked && (count != '0);
    assign missing_sync = din_valid && !frame_sync && is_locked && (count == '0);
    assign take         = din_valid && !frame_sync && is_locked && (count != '0);

    tdm_slot_counter #(
        .NCH (NCH),
        .SW  (SW)
    ) u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (missing_sync),
        .load1 (start),
        .inc   (take),
        .count (count),
        .wrap  (wrap)
    );

    // The last slot bypasses the shadow buffer and lands in ch_data directly.
    generate
        for (genvar gi = 0; gi < NCH - 1; gi++) begin : g_shadow
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shadow_reg[gi] <= '0;
                end else if ((start && gi == 0) || (take && count == SW'(gi))) begin
                    shadow_reg[gi] <= din;
                end
            end
            assign ch_data_next[gi*W +: W] = shadow_reg[gi];
        end
    endgenerate

    assign ch_data_next[(NCH-1)*W +: W] = din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= HUNT;
            ch_data_reg     <= '0;
            frame_valid_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
        end else begin
            frame_valid_reg <= wrap;
            sync_err_reg    <= early_sync || missing_sync;
            if (wrap) begin
                ch_data_reg <= ch_data_next;
            end
            if (start) begin
                state_reg <= LOCKED;
            end else if (missing_sync) begin
                state_reg <= HUNT;
            end
        end
    end

    assign ch_data     = ch_data_reg;
    assign frame_valid = frame_valid_reg;
    assign sync_err    = sync_err_reg;
    assign locked      = is_locked;
    assign slot_idx    = count;

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive-side counterpart of a 2:1-style channel mux used as a time-division transmitter.
- Accepts one time-interleaved sample stream with a frame marker and redistributes the samples into NCH parallel channel registers.
- Presents each complete frame atomically with a one-cycle valid pulse.
- Sits between the serial TDM link and the per-channel consumers.

Parameters:
- NCH, 4, number of channels (slots) per frame; legal range 2..16.
- W, 8, sample width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  W  sample for the current slot.
- din_valid  input  1  din carries a sample this cycle.
- frame_sync  input  1  qualified by din_valid; marks the sample as slot 0.
- ch_data  output  NCH*W  frame output; channel k occupies bits [k*W +: W].
- frame_valid  output  1  one-cycle pulse: ch_data holds a new complete frame.
- locked  output  1  high while the demux is aligned to the frame.
- sync_err  output  1  one-cycle pulse on a framing error.
- slot_idx  output  clog2(NCH)  index of the next expected slot.

Behaviour:
- Reset (async assert, sync release): state HUNT, slot counter 0, shadow buffer 0, ch_data 0, frame_valid 0, locked 0, sync_err 0.
- A sample is accepted only when din_valid is 1. Cycles with din_valid 0 change nothing: counter holds and no pulses are issued.
- HUNT state:
  - Samples without frame_sync are discarded.
  - An accepted sample with frame_sync is written to shadow slot 0, the counter is set to 1, and the state moves to LOCKED.
- LOCKED state:
  - An accepted sample without frame_sync is written to shadow[counter], then the counter increments.
  - An accepted sample with frame_sync when counter == 0 is the normal start of a frame: write to slot 0, counter becomes 1.
  - An accepted sample with frame_sync when counter != 0 is an early sync. Pulse sync_err on the next cycle, drop the partial frame (no frame_valid), write the sample to slot 0, counter becomes 1, and stay LOCKED.
  - An accepted sample without frame_sync when counter == 0 is a missing sync. Pulse sync_err, discard the sample, go to HUNT, and drive locked to 0.
- Frame completion: when slot NCH-1 is accepted, the counter wraps to 0. On the next rising edge, ch_data is loaded with the full shadow buffer (including that last sample) and frame_valid pulses high for exactly one cycle. Latency is 1 cycle from the last-slot acceptance edge.
- ch_data holds its value between frames and never shows a partially updated frame.
- Back-to-back frames with din_valid held continuously high give frame_valid every NCH cycles, with no bubbles.
- locked is 1 exactly while the state is LOCKED. It is registered and asserts the cycle after the first frame_sync is accepted.
- slot_idx is the counter value; it reads 0 in HUNT.
- sync_err and frame_valid are never both high in the same cycle.
- Asserting rst mid-frame clears the state immediately; the partial frame is lost and ch_data returns to 0.
- Counter wrap is explicit at NCH-1 (NCH need not be a power of two). Out-of-range counter values are unreachable.

Decomposition:
- Shared package/header: state encoding localparams (HUNT=0, LOCKED=1) and a clog2 constant function, reused by a future tdm_mux transmitter.
- One natural sub-module: tdm_slot_counter (mod-NCH counter with sync load and wrap flag). Everything else stays in the top level.

Test Plan:
- Reset then lock (NCH=4, W=8): after reset, send A0(sync),A1,A2,A3 with din_valid=1 → one cycle after A3, frame_valid=1 and ch_data=0xA3A2A1A0; locked=1 from the cycle after A0.
- Gaps: same frame with din_valid=0 for 3 cycles between A1 and A2 → identical ch_data, frame_valid delayed 3 cycles, no sync_err.
- Hunt discard: send 0x11,0x22 without sync, then 0x55(sync),0x66,0x77,0x88 → ch_data=0x88776655; the first two samples never appear; no sync_err.
- Early sync: while locked, send 0x01(sync),0x02, then 0x10(sync),0x20,0x30,0x40 → sync_err pulse after 0x10, no frame_valid for the partial frame, then ch_data=0x40302010.
- Missing sync: after a complete frame, send 0x99 without sync → sync_err pulse, locked=0, ch_data unchanged, next frame_valid only after a new sync-aligned frame.
- Mid-frame reset: assert rst after 2 slots → all outputs 0 immediately; a subsequent clean frame 0xD0..0xD3 gives ch_data=0xD3D2D1D0.
